// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, MSB-first payload, optional even parity, stop bit.
// Completed frames go to a single holding register with a valid/ready handshake and overrun flag.
module serial_frame_rx #(
  parameter int DATA_W    = 8,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sin,
  input  logic              sin_en,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic              perr_pend, perr_pend_next;
  logic              complete;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of block order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      shreg     <= '0;
      perr_pend <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      shreg     <= shreg_next;
      perr_pend <= perr_pend_next;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    shreg_next     = shreg;
    perr_pend_next = perr_pend;
    complete       = 1'b0;

    if (sin_en) begin
      unique case (state)
        IDLE: begin
          if (sin) begin
            state_next     = DATA;
            cnt_next       = '0;
            shreg_next     = '0;
            perr_pend_next = 1'b0;
          end
        end
        DATA: begin
          shreg_next = {shreg[DATA_W-2:0], sin};
          if (cnt == LAST_BIT) begin
            cnt_next   = '0;
            state_next = PARITY_EN ? PARITY : STOP;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          perr_pend_next = (^shreg) ^ sin;
          state_next     = STOP;
        end
        STOP: begin
          // A high stop bit only flags the frame; the next start must come from IDLE.
          complete   = 1'b1;
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // NOTE: the holding register is a handful of flops, so it is reset along
  // with control state to keep dout at a known 0 after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        // Load when empty, or when the held frame is being accepted this same edge.
        if (!dout_valid || dout_ready) begin
          dout       <= shreg;
          parity_err <= PARITY_EN ? perr_pend : 1'b0;
          frame_err  <= sin;
          dout_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Randomized bench for serial_frame_rx: a frame-level model feeds a scoreboard queue,
// a negedge monitor compares DUT outputs; a second no-parity instance gets a directed frame.
module tb_serial_frame_rx;

  localparam int DW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          perr;
    logic          ferr;
  } frame_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sin = 1'b0;
  logic          sin_en = 1'b0;
  logic          dout_ready = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid, parity_err, frame_err, overrun, busy;

  logic          sin_np = 1'b0;
  logic          sin_en_np = 1'b0;
  logic          dout_ready_np = 1'b0;
  logic [DW-1:0] dout_np;
  logic          dout_valid_np, parity_err_np, frame_err_np, overrun_np, busy_np;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;  // 0: never ready, 1: always ready, 2: random

  always #5 clk = ~clk;

  serial_frame_rx #(.DATA_W(DW), .PARITY_EN(1'b1)) u_dut (
    .clk(clk), .reset(reset), .sin(sin), .sin_en(sin_en),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );

  serial_frame_rx #(.DATA_W(DW), .PARITY_EN(1'b0)) u_dut_np (
    .clk(clk), .reset(reset), .sin(sin_np), .sin_en(sin_en_np),
    .dout(dout_np), .dout_valid(dout_valid_np), .dout_ready(dout_ready_np),
    .parity_err(parity_err_np), .frame_err(frame_err_np), .overrun(overrun_np), .busy(busy_np)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model: collects qualified bits into a list and
  // interprets the list once it holds payload + parity + stop.
  logic   in_frame = 1'b0;
  logic   bits[$];
  logic   m_full = 1'b0;
  logic   m_ovr = 1'b0;
  frame_t m_held = '0;
  frame_t m_new;
  logic   m_done;
  frame_t exp_q[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_frame = 1'b0;
      bits.delete();
      m_full = 1'b0;
      m_ovr  = 1'b0;
      m_held = '0;
      exp_q.delete();
    end else begin
      m_done = 1'b0;
      m_ovr  = 1'b0;
      if (sin_en) begin
        if (!in_frame) begin
          if (sin) begin
            in_frame = 1'b1;
            bits.delete();
          end
        end else begin
          bits.push_back(sin);
          if (bits.size() == DW + 2) begin
            for (int i = 0; i < DW; i++) m_new.data[DW-1-i] = bits[i];
            m_new.perr = (^m_new.data) ^ bits[DW];
            m_new.ferr = bits[DW+1];
            m_done   = 1'b1;
            in_frame = 1'b0;
          end
        end
      end
      if (m_done) begin
        if (!m_full || dout_ready) begin
          m_held = m_new;
          m_full = 1'b1;
          exp_q.push_back(m_new);
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_full && dout_ready) begin
        m_full = 1'b0;
      end
    end
  end

  // Monitor: compares presented outputs every cycle and pops the scoreboard on handshakes.
  always @(negedge clk) begin
    if (reset) begin
      check("dout_valid", 32'(dout_valid), 32'(m_full));
      check("dout", 32'(dout), 32'(m_held.data));
      check("parity_err", 32'(parity_err), 32'(m_held.perr));
      check("frame_err", 32'(frame_err), 32'(m_held.ferr));
      check("overrun", 32'(overrun), 32'(m_ovr));
      check("busy", 32'(busy), 32'(in_frame));
      if (dout_valid && dout_ready) begin
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          frame_t f;
          f = exp_q.pop_front();
          check("sb_frame", 32'({dout, parity_err, frame_err}), 32'(f));
        end
      end
    end
  end

  function automatic logic pick_ready();
    case (ready_mode)
      0:       return 1'b0;
      1:       return 1'b1;
      default: return 1'($urandom_range(1, 0));
    endcase
  endfunction

  // Optional unqualified cycles with noise on sin, then one qualified bit.
  task automatic drive_bit(input logic b, input int gmin, input int gmax);
    int n;
    n = int'($urandom_range(gmax, gmin));
    repeat (n) begin
      sin = 1'($urandom_range(1, 0));
      sin_en = 1'b0;
      dout_ready = pick_ready();
      @(posedge clk); #1;
    end
    sin = b;
    sin_en = 1'b1;
    dout_ready = pick_ready();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      sin = 1'b0;
      sin_en = 1'($urandom_range(1, 0));
      dout_ready = pick_ready();
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] p, input logic par_flip, input logic stop,
                            input int gmin, input int gmax, input int stop_ready_mode);
    int saved;
    drive_bit(1'b1, gmin, gmax);
    for (int i = DW - 1; i >= 0; i--) drive_bit(p[i], gmin, gmax);
    drive_bit((^p) ^ par_flip, gmin, gmax);
    saved = ready_mode;
    ready_mode = stop_ready_mode;
    drive_bit(stop, gmin, gmax);
    ready_mode = saved;
    sin = 1'b0;
    sin_en = 1'b0;
    dout_ready = pick_ready();
  endtask

  task automatic consume();
    ready_mode = 1;
    idle(1);
    ready_mode = 0;
    dout_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, 32'({dout, dout_valid, parity_err, frame_err, overrun, busy}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    idle(2);

    // Clean 0xA5 frame, held unconsumed.
    ready_mode = 0;
    send_frame(8'hA5, 1'b0, 1'b0, 0, 0, 0);
    check("a5_valid", 32'(dout_valid), 32'd1);
    check("a5_data", 32'(dout), 32'hA5);
    check("a5_flags", 32'({parity_err, frame_err}), 32'd0);
    consume();

    // Parity error, then stop-bit error; both still delivered.
    send_frame(8'hA5, 1'b1, 1'b0, 0, 0, 0);
    check("perr_data", 32'(dout), 32'hA5);
    check("perr_flag", 32'(parity_err), 32'd1);
    consume();
    send_frame(8'hA5, 1'b0, 1'b1, 0, 0, 0);
    check("ferr_flag", 32'(frame_err), 32'd1);
    check("ferr_idle", 32'(busy), 32'd0);
    idle(2);
    consume();

    // Overrun: 0x3C dropped while 0xA5 is held; then replaced when accepted on the completion edge.
    send_frame(8'hA5, 1'b0, 1'b0, 0, 0, 0);
    send_frame(8'h3C, 1'b0, 1'b0, 0, 0, 0);
    check("ovr_pulse", 32'(overrun), 32'd1);
    check("ovr_keep", 32'(dout), 32'hA5);
    idle(1);
    check("ovr_single", 32'(overrun), 32'd0);
    send_frame(8'h3C, 1'b0, 1'b0, 0, 0, 1);
    check("swap_data", 32'(dout), 32'h3C);
    check("swap_valid", 32'(dout_valid), 32'd1);
    check("swap_no_ovr", 32'(overrun), 32'd0);
    consume();

    // Qualifier toggling every cycle.
    send_frame(8'h5A, 1'b0, 1'b0, 1, 1, 0);
    check("toggle_data", 32'(dout), 32'h5A);
    consume();

    // Reset mid-frame, then a clean 0xFF frame.
    drive_bit(1'b1, 0, 0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, 0, 0);
    sin_en = 1'b0;
    reset = 1'b0;
    #2;
    check_all_zero("midreset");
    @(posedge clk); #1;
    reset = 1'b1;
    idle(1);
    send_frame(8'hFF, 1'b0, 1'b0, 0, 0, 0);
    check("ff_data", 32'(dout), 32'hFF);
    check("ff_flags", 32'({parity_err, frame_err}), 32'd0);
    consume();

    // Randomized traffic.
    for (int k = 0; k < 40; k++) begin
      ready_mode = int'($urandom_range(2, 0));
      send_frame(8'($urandom), 1'($urandom_range(3, 0) == 0), 1'($urandom_range(4, 0) == 0),
                 0, int'($urandom_range(2, 0)), int'($urandom_range(2, 0)));
      idle(int'($urandom_range(3, 0)));
    end
    ready_mode = 1;
    idle(3);
    ready_mode = 0;
    dout_ready = 1'b0;
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    // No-parity instance: 1, 0000_0001, 0 completes on the 10th qualified edge.
    for (int i = 0; i < 10; i++) begin
      sin_np = (i == 0 || i == 8);
      sin_en_np = 1'b1;
      @(posedge clk); #1;
      if (i == 8) check("np_not_yet", 32'(dout_valid_np), 32'd0);
    end
    sin_en_np = 1'b0;
    check("np_valid", 32'(dout_valid_np), 32'd1);
    check("np_data", 32'(dout_np), 32'h01);
    check("np_flags", 32'({parity_err_np, frame_err_np}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
SERIAL_FRAME_RX -- requirements
Module: serial_frame_rx

Interface
REQ-001 Parameter DATA_W, default 8, payload bits per frame (range 4..16).
REQ-002 Parameter PARITY_EN, default 1, 1 = even-parity bit present after payload, 0 = no parity bit.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port sin  input  1  serial bit stream, driven by the upstream 4-bit serial shift register output.
REQ-006 Port sin_en  input  1  bit qualifier; sin sampled only on rising edges where sin_en=1.
REQ-007 Port dout  output  DATA_W  received payload, first received bit in dout[DATA_W-1].
REQ-008 Port dout_valid  output  1  dout holds an unconsumed frame.
REQ-009 Port dout_ready  input  1  consumer accepts dout when dout_valid=1 and dout_ready=1.
REQ-010 Port parity_err  output  1  parity mismatch flag for frame in dout; 0 when PARITY_EN=0.
REQ-011 Port frame_err  output  1  stop-bit error flag for frame in dout.
REQ-012 Port overrun  output  1  one-cycle pulse, completed frame dropped because holding register full.
REQ-013 Port busy  output  1  1 whenever FSM is not IDLE.

Function
REQ-014 Frame format SHALL be: start bit 1, DATA_W payload bits MSB first, parity bit (if PARITY_EN), stop bit 0; line idles at 0.
REQ-015 FSM states SHALL be IDLE, DATA, PARITY, STOP; all transitions occur only on edges with sin_en=1; sin_en=0 holds state, bit counter and shift register.
REQ-016 IDLE -> DATA on sampled sin=1; sampled sin=0 stays IDLE.
REQ-017 DATA SHALL shift sampled bit into an internal DATA_W shift register (left shift, new bit at LSB) and count bits; after DATA_W-th bit -> PARITY if PARITY_EN=1, else STOP.
REQ-018 PARITY SHALL sample one bit; parity error = XOR of payload bits XOR sampled bit (even parity); -> STOP.
REQ-019 STOP SHALL sample one bit; frame error = sampled bit is 1; -> IDLE unconditionally, frame complete.
REQ-020 On frame completion with holding register empty, or full and dout_ready=1 in the same cycle, dout, parity_err, frame_err SHALL load and dout_valid SHALL be 1 from the next cycle; latency = the stop-bit sampling edge.
REQ-021 Frames with parity_err or frame_err SHALL still be delivered, flagged.
REQ-022 dout_valid=1 and dout_ready=1 with no completion SHALL clear dout_valid on that edge; dout, flags hold their values.
REQ-023 Completion while dout_valid=1 and dout_ready=0 SHALL drop the new frame, keep old dout/flags, and pulse overrun for exactly one cycle.
REQ-024 dout, parity_err, frame_err SHALL remain stable while dout_valid=1 and not accepted.
REQ-025 A stop-bit error SHALL NOT be treated as a new start bit; the next start is detected only from IDLE.
REQ-026 busy SHALL be combinationally derived from the FSM state; all other outputs registered.

Reset
REQ-027 reset=0 SHALL asynchronously force IDLE, bit counter 0, shift register 0, dout=0, dout_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; after release the block waits for a fresh start bit.
REQ-029 First sampling edge after reset release SHALL be treated as IDLE.

Verification
REQ-030 DATA_W=8, PARITY_EN=1, sin_en=1, dout_ready=0; bits 1,1,0,1,0,0,1,0,1,0,0 -> dout=0xA5, dout_valid=1 on the cycle after the 11th edge, parity_err=0, frame_err=0, busy high 10 cycles.
REQ-031 Same frame with parity bit 1 -> dout=0xA5, parity_err=1; with stop bit 1 -> frame_err=1, FSM back in IDLE.
REQ-032 0xA5 frame held unconsumed, then 0x3C frame completes with dout_ready=0 -> overrun one-cycle pulse, dout stays 0xA5; repeat with dout_ready=1 on completion edge -> dout=0x3C, dout_valid stays 1, no overrun.
REQ-033 sin_en toggling 1,0,1,0 during 0x5A frame -> dout=0x5A after 11 qualified bits; no change on sin_en=0 edges.
REQ-034 reset pulsed low after 4 payload bits, then full 0xFF frame (parity 0) -> only 0xFF delivered, no errors; all outputs 0 during reset.
REQ-035 PARITY_EN=0, bits 1,0,0,0,0,0,0,0,1,0 -> dout=0x01, parity_err=0, completion on the 10th edge.
